// File: rtl/cic_decimator.sv
// N-stage CIC (Hogenauer) decimator: 1-bit PDM stream in, saturated signed PCM out.
// Optional macro CIC_OVF_FLAG_EN adds a sticky saturation flag (ovf_clr / ovf_sticky).
module cic_decimator #(
    parameter int N_STAGES = 4,
    parameter int DECIM    = 32,
    parameter int ACC_W    = 22,
    parameter int OUT_W    = 17
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pdm_in,
    input  logic             pdm_valid,
`ifdef CIC_OVF_FLAG_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [OUT_W-1:0] y_out,
    output logic             out_valid
);
    localparam int CNT_W = $clog2(DECIM);
    localparam int SHIFT = N_STAGES * CNT_W + 1 - OUT_W;
    localparam int SW    = ACC_W + OUT_W;
    localparam logic signed [SW-1:0] MAX_S = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

    logic [ACC_W-1:0]     x;
    logic [ACC_W-1:0]     integ_q [N_STAGES];
    logic [ACC_W-1:0]     integ_d [N_STAGES];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tick;
    logic [ACC_W-1:0]     pipe_q [N_STAGES+1];
    logic [ACC_W-1:0]     pipe_d [N_STAGES+1];
    logic [ACC_W-1:0]     dly_q [N_STAGES];
    logic [ACC_W-1:0]     dly_d [N_STAGES];
    logic [N_STAGES:0]    vld_q, vld_d;
    logic signed [SW-1:0] comb_ext, scaled;
    logic [OUT_W-1:0]     y_out_q, y_out_d;
    logic                 out_valid_q, out_valid_d;

    assign comb_ext = {{OUT_W{pipe_q[N_STAGES][ACC_W-1]}}, pipe_q[N_STAGES]};

    generate
        if (SHIFT >= 0) begin : g_shr
            assign scaled = comb_ext >>> SHIFT;
        end else begin : g_shl
            assign scaled = comb_ext <<< (-SHIFT);
        end
    endgenerate

    always_comb begin
        x       = pdm_in ? ACC_W'(1) : {ACC_W{1'b1}};
        integ_d = integ_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        // Each integrator adds its neighbour's previous value: one register per stage.
        if (pdm_valid) begin
            integ_d[0] = integ_q[0] + x;
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            tick  = (cnt_q == CNT_W'(DECIM - 1));
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        // vld_q[k] marks pipe_q[k] as holding a fresh decimated sample.
        vld_d  = {vld_q[N_STAGES-1:0], tick};
        pipe_d = pipe_q;
        dly_d  = dly_q;
        if (tick) begin
            pipe_d[0] = integ_d[N_STAGES-1];
        end
        for (int k = 1; k <= N_STAGES; k++) begin
            if (vld_q[k-1]) begin
                pipe_d[k]  = pipe_q[k-1] - dly_q[k-1];
                dly_d[k-1] = pipe_q[k-1];
            end
        end

        out_valid_d = vld_q[N_STAGES];
        y_out_d     = y_out_q;
        if (vld_q[N_STAGES]) begin
            if (scaled > MAX_S) begin
                y_out_d = MAX_S[OUT_W-1:0];
            end else if (scaled < MIN_S) begin
                y_out_d = MIN_S[OUT_W-1:0];
            end else begin
                y_out_d = scaled[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            for (int k = 0; k <= N_STAGES; k++) begin
                pipe_q[k] <= '0;
            end
            cnt_q       <= '0;
            vld_q       <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            pipe_q      <= pipe_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;

`ifdef CIC_OVF_FLAG_EN
    logic sat;
    logic ovf_q, ovf_d;

    // A saturating output in the same cycle as a clear leaves the flag set.
    always_comb begin
        sat   = vld_q[N_STAGES] && ((scaled > MAX_S) || (scaled < MIN_S));
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (sat)     ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_sticky = ovf_q;
`endif
endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: table-driven steady-state patterns, reset corner
// sequences and a randomized stream checked against an FIR-form model of the CIC.
module tb_cic_decimator;
  localparam int N_STAGES = 4;
  localparam int DECIM    = 32;
  localparam int ACC_W    = 22;
  localparam int OUT_W    = 17;
  localparam int LAT      = N_STAGES + 2;
  localparam int HLEN     = N_STAGES * (DECIM - 1) + 1;
  localparam int SHIFT    = 4;
  localparam int NOUT     = 8;
  localparam int SETTLE   = N_STAGES + 1;

  typedef struct {
    logic [7:0] pat;
    int         plen;
    int         gap;
    int         exp_y;
    logic       exp_ovf;
  } vec_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             pdm_in;
  logic             pdm_valid;
  logic [OUT_W-1:0] y_out;
  logic             out_valid;
`ifdef CIC_OVF_FLAG_EN
  logic             ovf_clr;
  logic             ovf_sticky;
`endif

  cic_decimator #(
    .N_STAGES(N_STAGES), .DECIM(DECIM), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pdm_in    (pdm_in),
    .pdm_valid (pdm_valid),
`ifdef CIC_OVF_FLAG_EN
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky),
`endif
    .y_out     (y_out),
    .out_valid (out_valid)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int               h[HLEN];
  int               xs[$];
  int               n_samp;
  logic [OUT_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic             exp_clip_q[$];
  logic [OUT_W-1:0] rx_q[$];
  int               rx_cyc_q[$];
  vec_t             vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Impulse response of N cascaded length-DECIM boxcars.
  task automatic build_h();
    int tmp[HLEN];
    for (int i = 0; i < HLEN; i++) h[i] = (i < DECIM) ? 1 : 0;
    for (int s = 1; s < N_STAGES; s++) begin
      tmp = h;
      for (int i = 0; i < HLEN; i++) begin
        int acc = 0;
        for (int k = 0; k < DECIM; k++) if (i - k >= 0) acc += tmp[i - k];
        h[i] = acc;
      end
    end
  endtask

  // Output after n_samp samples; samples before reset count as zero, and the registered
  // integrator cascade delays the window by N_STAGES-1 samples.
  function automatic logic [OUT_W-1:0] model_out(output logic clip);
    longint acc = 0;
    for (int j = 0; j < HLEN; j++) begin
      int idx = n_samp - (N_STAGES - 1) - j;
      if (idx >= 1) acc += longint'(h[j]) * longint'(xs[idx - 1]);
    end
    acc  = acc >>> SHIFT;
    clip = 1'b0;
    if (acc > 65535) begin acc = 65535; clip = 1'b1; end
    if (acc < -65536) begin acc = -65536; clip = 1'b1; end
    return OUT_W'(acc);
  endfunction

  // driver tasks
  task automatic step(input logic v, input logic b);
    logic clip;
    @(posedge CLK); #1;
    pdm_valid = v;
    pdm_in    = b;
    if (v) begin
      xs.push_back(b ? 1 : -1);
      n_samp++;
      if (n_samp % DECIM == 0) begin
        exp_q.push_back(model_out(clip));
        exp_clip_q.push_back(clip);
        exp_cyc_q.push_back(cyc + LAT);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST       = 1'b1;
    pdm_valid = 1'b0;
    exp_q.delete(); exp_cyc_q.delete(); exp_clip_q.delete();
    rx_q.delete(); rx_cyc_q.delete(); xs.delete();
    n_samp = 0;
    #1;
    check("rst_y_out", int'($signed(y_out)), 0);
    check("rst_out_valid", int'(out_valid), 0);
`ifdef CIC_OVF_FLAG_EN
    check("rst_ovf_sticky", int'(ovf_sticky), 0);
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 4) step(1'b0, 1'b0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // scoreboard: every out_valid pops one model sample and its due cycle
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got y_out=%0d with no sample due (t=%0t)",
                   $signed(y_out), $time);
        end else begin
          logic [OUT_W-1:0] e;
          int               ec;
          logic             ecl;
          e   = exp_q.pop_front();
          ec  = exp_cyc_q.pop_front();
          ecl = exp_clip_q.pop_front();
          check("y_out_model", int'($signed(y_out)), int'($signed(e)));
          check("latency_cycle", cyc, ec);
`ifdef CIC_OVF_FLAG_EN
          if (ecl) check("ovf_on_sat", int'(ovf_sticky), 1);
`else
          if (ecl) check("sat_value", int'($signed(y_out)), int'($signed(e)));
`endif
        end
        rx_q.push_back(y_out);
        rx_cyc_q.push_back(cyc);
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out_valid: got none, expected at cycle %0d (now %0d)",
                 exp_cyc_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        void'(exp_clip_q.pop_front());
      end
    end
  end

  task automatic run_vec(input int vi, input vec_t v);
    do_reset();
    for (int s = 0; s < NOUT * DECIM; s++) begin
      logic b;
      b = v.pat[s % v.plen];
      step(1'b1, b);
      for (int g = 1; g < v.gap; g++) step(1'b0, b);
    end
    drain();
    check($sformatf("n_outputs[v%0d]", vi), rx_q.size(), NOUT);
    for (int k = SETTLE - 1; k < rx_q.size(); k++)
      check($sformatf("steady_y[v%0d][%0d]", vi, k), int'($signed(rx_q[k])), v.exp_y);
    for (int k = 1; k < rx_cyc_q.size(); k++)
      check($sformatf("period[v%0d][%0d]", vi, k), rx_cyc_q[k] - rx_cyc_q[k-1], DECIM * v.gap);
`ifdef CIC_OVF_FLAG_EN
    check($sformatf("ovf_final[v%0d]", vi), int'(ovf_sticky), int'(v.exp_ovf));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    pdm_in    = 1'b0;
    pdm_valid = 1'b0;
`ifdef CIC_OVF_FLAG_EN
    ovf_clr   = 1'b0;
`endif
    n_samp    = 0;
    build_h();

    vecs[0] = '{pat: 8'h01, plen: 1, gap: 1, exp_y:  65535, exp_ovf: 1'b1};
    vecs[1] = '{pat: 8'h00, plen: 1, gap: 1, exp_y: -65536, exp_ovf: 1'b0};
    vecs[2] = '{pat: 8'h01, plen: 2, gap: 1, exp_y:      0, exp_ovf: 1'b0};
    vecs[3] = '{pat: 8'h07, plen: 4, gap: 3, exp_y:  32768, exp_ovf: 1'b0};
    vecs[4] = '{pat: 8'h7F, plen: 8, gap: 1, exp_y:  49152, exp_ovf: 1'b0};
    vecs[5] = '{pat: 8'h01, plen: 4, gap: 2, exp_y: -32768, exp_ovf: 1'b0};

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset at count 17 discards the partial frame; next output 6 cycles after 32nd sample.
    do_reset();
    for (int s = 0; s < 2 * DECIM + 17; s++) step(1'b1, 1'b1);
    do_reset();
    for (int s = 0; s < DECIM; s++) step(1'b1, 1'b1);
    drain();
    check("rst_midframe_outputs", rx_q.size(), 1);

    // Reset while a decimated sample is still travelling through the combs.
    do_reset();
    for (int s = 0; s < DECIM + 1; s++) step(1'b1, 1'b1);
    do_reset();
    drain();
    check("rst_inflight_outputs", rx_q.size(), 0);

    // Long full-scale run: integrators wrap many times, output must stay clipped.
    do_reset();
    for (int s = 0; s < 24 * DECIM; s++) step(1'b1, 1'b1);
    drain();
    check("long_outputs", rx_q.size(), 24);
    for (int k = SETTLE - 1; k < rx_q.size(); k++)
      check($sformatf("long_y[%0d]", k), int'($signed(rx_q[k])), 65535);
`ifdef CIC_OVF_FLAG_EN
    check("ovf_long_set", int'(ovf_sticky), 1);
    @(posedge CLK); #1 ovf_clr = 1'b1;
    @(posedge CLK); #1 ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf_sticky), 0);
    ovf_clr = 1'b1;
    for (int s = 0; s < DECIM; s++) step(1'b1, 1'b1);
    drain();
    check("ovf_clr_held_after", int'(ovf_sticky), 0);
    ovf_clr = 1'b0;
    for (int s = 0; s < DECIM; s++) step(1'b1, 1'b1);
    drain();
    check("ovf_reset_again", int'(ovf_sticky), 1);
`endif

    // Randomized stream with random density and random pdm_valid gaps.
    do_reset();
    begin
      int bias = 50;
      while (n_samp < 40 * DECIM) begin
        if (n_samp % DECIM == 0) bias = $urandom_range(0, 100);
        step(1'b1, logic'($urandom_range(0, 99) < bias));
        repeat ($urandom_range(0, 2)) step(1'b0, logic'($urandom_range(0, 1)));
      end
    end
    drain();
    check("random_outputs", rx_q.size(), 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
